// File: rtl/chess_layout_writer_pkg.sv
// rtl/chess_layout_writer_pkg.sv - shared codes, sizes, FSM encoding and reset board for the chess layout writer
package chess_pkg;

  localparam int SQUARE_WIDTH  = 8;
  localparam int CHESS_SQUARES = 64;
  localparam int LAYOUT_W      = SQUARE_WIDTH * CHESS_SQUARES;

  localparam logic [2:0] P_EMPTY  = 3'd0;
  localparam logic [2:0] P_KING   = 3'd1;
  localparam logic [2:0] P_QUEEN  = 3'd2;
  localparam logic [2:0] P_BISHOP = 3'd3;
  localparam logic [2:0] P_KNIGHT = 3'd4;
  localparam logic [2:0] P_ROOK   = 3'd5;
  localparam logic [2:0] P_PAWN   = 3'd6;

  localparam logic C_DARK  = 1'b0;
  localparam logic C_LIGHT = 1'b1;

  localparam logic [1:0] S_NONE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_SEL  = 2'd2;
  localparam logic [1:0] S_POST = 2'd3;

  localparam logic [5:0] CURSOR_RESET = 6'd52;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_COMMIT = 2'd2
  } fsm_state_e;

  function automatic logic [CHESS_SQUARES-1:0][3:0] reset_board();
    logic [CHESS_SQUARES-1:0][3:0] b;
    logic [2:0] p;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0, 7:    p = P_ROOK;
        1, 6:    p = P_KNIGHT;
        2, 5:    p = P_BISHOP;
        3:       p = P_QUEEN;
        default: p = P_KING;
      endcase
      b[c]      = {C_DARK, p};
      b[8 + c]  = {C_DARK, P_PAWN};
      b[48 + c] = {C_LIGHT, P_PAWN};
      b[56 + c] = {C_LIGHT, p};
    end
    return b;
  endfunction

  function automatic logic [LAYOUT_W-1:0] reset_layout();
    logic [CHESS_SQUARES-1:0][3:0] b;
    logic [LAYOUT_W-1:0] l;
    b = reset_board();
    l = '0;
    for (int i = 0; i < CHESS_SQUARES; i++) begin
      l[i*SQUARE_WIDTH +: SQUARE_WIDTH] = {2'b00, (6'(i) == CURSOR_RESET) ? S_PRE : S_NONE, b[i]};
    end
    return l;
  endfunction

  localparam logic [CHESS_SQUARES-1:0][3:0] RESET_BOARD  = reset_board();
  localparam logic [LAYOUT_W-1:0]           RESET_LAYOUT = reset_layout();

endpackage

// File: rtl/chess_layout_writer_if.sv
// rtl/chess_layout_writer_if.sv - layout bus from the writer to the chess renderer
interface chess_layout_writer_if;
  import chess_pkg::*;

  logic [LAYOUT_W-1:0] Layout;
  logic [5:0]          CursorIdx;
  logic                Turn;
  logic                MoveDone;
  logic [3:0]          Captured;

  modport master (output Layout, CursorIdx, Turn, MoveDone, Captured);
  modport slave  (input  Layout, CursorIdx, Turn, MoveDone, Captured);
endinterface

// File: rtl/chess_layout_writer_key_debouncer.sv
// rtl/chess_layout_writer_key_debouncer.sv - 2-flop synchroniser, stability counter and one-cycle edge event
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = 19,
  parameter bit RESET_LEVEL     = 1'b1,
  parameter bit ANY_EDGE        = 1'b0
) (
  input  logic clock,
  input  logic resetApp,
  input  logic din_i,
  output logic event_o
);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [DEB_W-1:0] cnt_q;
  logic             event_q;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      sync_q  <= {2{RESET_LEVEL}};
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      event_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          event_q <= ANY_EDGE | ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/chess_layout_writer.sv
// rtl/chess_layout_writer.sv - cursor, select/confirm FSM and move application driving the layout bus
module chess_layout_writer
  import chess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = 19
) (
  input  logic                  clock,
  input  logic                  resetApp,
  input  logic                  KeyLeft,
  input  logic                  KeyUp,
  input  logic                  KeyDown,
  input  logic                  KeyRight,
  input  logic                  LockSwitch,
  chess_layout_writer_if.master bus
);

  logic ev_up, ev_down, ev_left, ev_right, ev_lock;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W), .RESET_LEVEL(1'b1), .ANY_EDGE(1'b0))
    u_deb_up    (.clock(clock), .resetApp(resetApp), .din_i(KeyUp),      .event_o(ev_up));
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W), .RESET_LEVEL(1'b1), .ANY_EDGE(1'b0))
    u_deb_down  (.clock(clock), .resetApp(resetApp), .din_i(KeyDown),    .event_o(ev_down));
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W), .RESET_LEVEL(1'b1), .ANY_EDGE(1'b0))
    u_deb_left  (.clock(clock), .resetApp(resetApp), .din_i(KeyLeft),    .event_o(ev_left));
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W), .RESET_LEVEL(1'b1), .ANY_EDGE(1'b0))
    u_deb_right (.clock(clock), .resetApp(resetApp), .din_i(KeyRight),   .event_o(ev_right));
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W), .RESET_LEVEL(1'b0), .ANY_EDGE(1'b1))
    u_deb_lock  (.clock(clock), .resetApp(resetApp), .din_i(LockSwitch), .event_o(ev_lock));

  fsm_state_e                    state_q, state_d;
  logic [CHESS_SQUARES-1:0][3:0] board_q, board_d;
  logic [LAYOUT_W-1:0]           layout_q, layout_d;
  logic [5:0]                    cursor_q, cursor_d, src_q, src_d, post_q, post_d;
  logic                          post_vld_q, post_vld_d, turn_q, turn_d;
  logic                          move_done_q, move_done_d, lock_pend_q, lock_pend_d;
  logic [3:0]                    captured_q, captured_d, key_pend_q, key_pend_d;

  logic [3:0] keys, sq;
  logic       lock_now;
  logic [2:0] row, col;
  logic [1:0] sel;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    cursor_d    = cursor_q;
    src_d       = src_q;
    post_d      = post_q;
    post_vld_d  = post_vld_q;
    turn_d      = turn_q;
    move_done_d = 1'b0;
    captured_d  = captured_q;
    key_pend_d  = 4'b0;
    lock_pend_d = 1'b0;
    keys        = key_pend_q | {ev_up, ev_down, ev_left, ev_right};
    lock_now    = ev_lock | lock_pend_q;
    row         = cursor_q[5:3];
    col         = cursor_q[2:0];
    sq          = board_q[cursor_q];
    sel         = S_NONE;

    if (state_q == ST_COMMIT) begin
      // Input events arriving now are parked and replayed in IDLE.
      key_pend_d          = keys;
      lock_pend_d         = lock_now;
      board_d[cursor_q]   = board_q[src_q];
      board_d[src_q]      = 4'h0;
      captured_d          = board_q[cursor_q];
      move_done_d         = 1'b1;
      turn_d              = ~turn_q;
      post_d              = cursor_q;
      post_vld_d          = 1'b1;
      state_d             = ST_IDLE;
    end else if (|keys) begin
      if (keys[3])      cursor_d = {row - 3'd1, col};
      else if (keys[2]) cursor_d = {row + 3'd1, col};
      else if (keys[1]) cursor_d = {row, col - 3'd1};
      else              cursor_d = {row, col + 3'd1};
      lock_pend_d = lock_now;
    end else if (lock_now) begin
      if (state_q == ST_IDLE) begin
        if (sq[2:0] != P_EMPTY && sq[3] == turn_q) begin
          src_d   = cursor_q;
          state_d = ST_HELD;
        end
      end else if (cursor_q == src_q) begin
        state_d = ST_IDLE;
      end else if (!(sq[2:0] != P_EMPTY && sq[3] == turn_q)) begin
        state_d = ST_COMMIT;
      end
    end

    // Held source outranks the cursor, which outranks the last destination.
    for (int i = 0; i < CHESS_SQUARES; i++) begin
      if (state_d != ST_IDLE && src_d == 6'(i))  sel = S_SEL;
      else if (cursor_d == 6'(i))                sel = S_PRE;
      else if (post_vld_d && post_d == 6'(i))    sel = S_POST;
      else                                       sel = S_NONE;
      layout_d[i*SQUARE_WIDTH +: SQUARE_WIDTH] = {2'b00, sel, board_d[i]};
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_q     <= ST_IDLE;
      board_q     <= RESET_BOARD;
      layout_q    <= RESET_LAYOUT;
      cursor_q    <= CURSOR_RESET;
      src_q       <= '0;
      post_q      <= '0;
      post_vld_q  <= 1'b0;
      turn_q      <= C_LIGHT;
      move_done_q <= 1'b0;
      captured_q  <= '0;
      key_pend_q  <= '0;
      lock_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      layout_q    <= layout_d;
      cursor_q    <= cursor_d;
      src_q       <= src_d;
      post_q      <= post_d;
      post_vld_q  <= post_vld_d;
      turn_q      <= turn_d;
      move_done_q <= move_done_d;
      captured_q  <= captured_d;
      key_pend_q  <= key_pend_d;
      lock_pend_q <= lock_pend_d;
    end
  end

  assign bus.Layout    = layout_q;
  assign bus.CursorIdx = cursor_q;
  assign bus.Turn      = turn_q;
  assign bus.MoveDone  = move_done_q;
  assign bus.Captured  = captured_q;

endmodule

// File: tb/tb_chess_layout_writer.sv
// tb/tb_chess_layout_writer.sv - directed and randomised checks of chess_layout_writer against a board model
module tb_chess_layout_writer;

  logic clock = 1'b0;
  logic resetApp = 1'b1;
  logic KeyLeft = 1'b1, KeyUp = 1'b1, KeyDown = 1'b1, KeyRight = 1'b1, LockSwitch = 1'b0;

  chess_layout_writer_if bus ();

  chess_layout_writer #(.DEBOUNCE_CYCLES(4), .DEB_W(3)) dut (
    .clock(clock), .resetApp(resetApp), .KeyLeft(KeyLeft), .KeyUp(KeyUp),
    .KeyDown(KeyDown), .KeyRight(KeyRight), .LockSwitch(LockSwitch), .bus(bus.master)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int md_cnt = 0;

  always @(negedge clock) begin
    if (resetApp) md_cnt = 0;
    else if (bus.MoveDone) md_cnt = md_cnt + 1;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int m_piece [64];
  int m_col [64];
  int m_cur, m_turn, m_held, m_src, m_post, m_postv, m_capt, m_moves;

  function automatic void model_reset();
    int back [8];
    back = '{5, 4, 3, 2, 1, 3, 4, 5};
    for (int i = 0; i < 64; i++) begin
      m_piece[i] = 0;
      m_col[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      m_piece[c] = back[c];      m_col[c] = 0;
      m_piece[8 + c] = 6;        m_col[8 + c] = 0;
      m_piece[48 + c] = 6;       m_col[48 + c] = 1;
      m_piece[56 + c] = back[c]; m_col[56 + c] = 1;
    end
    m_cur = 52; m_turn = 1; m_held = 0; m_src = 0;
    m_post = 0; m_postv = 0; m_capt = 0; m_moves = 0;
  endfunction

  function automatic logic [511:0] model_layout();
    logic [511:0] l;
    int s;
    l = '0;
    for (int i = 0; i < 64; i++) begin
      if (m_held != 0 && i == m_src) s = 2;
      else if (i == m_cur)           s = 1;
      else if (m_postv != 0 && i == m_post) s = 3;
      else                           s = 0;
      l[i*8 +: 8] = 8'(s * 16 + m_col[i] * 8 + m_piece[i]);
    end
    return l;
  endfunction

  function automatic void model_key(input int dir);
    int r, c;
    r = m_cur / 8;
    c = m_cur % 8;
    case (dir)
      0: r = (r + 7) % 8;
      1: r = (r + 1) % 8;
      2: c = (c + 7) % 8;
      default: c = (c + 1) % 8;
    endcase
    m_cur = r * 8 + c;
  endfunction

  function automatic void model_lock();
    bit own;
    own = (m_piece[m_cur] != 0) && (m_col[m_cur] == m_turn);
    if (m_held == 0) begin
      if (own) begin
        m_held = 1;
        m_src = m_cur;
      end
    end else if (m_cur == m_src) begin
      m_held = 0;
    end else if (!own) begin
      m_capt = m_col[m_cur] * 8 + m_piece[m_cur];
      m_piece[m_cur] = m_piece[m_src];
      m_col[m_cur] = m_col[m_src];
      m_piece[m_src] = 0;
      m_col[m_src] = 0;
      m_turn = 1 - m_turn;
      m_post = m_cur;
      m_postv = 1;
      m_moves++;
      m_held = 0;
    end
  endfunction

  task automatic do_reset();
    resetApp = 1'b1;
    LockSwitch = 1'b0;
    {KeyLeft, KeyUp, KeyDown, KeyRight} = 4'hF;
    repeat (3) @(negedge clock);
    resetApp = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
  endtask

  task automatic press(input int dir);
    case (dir)
      0: KeyUp = 1'b0;
      1: KeyDown = 1'b0;
      2: KeyLeft = 1'b0;
      default: KeyRight = 1'b0;
    endcase
    repeat (10) @(negedge clock);
    {KeyLeft, KeyUp, KeyDown, KeyRight} = 4'hF;
    repeat (10) @(negedge clock);
    model_key(dir);
  endtask

  task automatic toggle_lock();
    LockSwitch = ~LockSwitch;
    repeat (15) @(negedge clock);
    model_lock();
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".layout"}, bus.Layout, model_layout());
    chk({tag, ".cursor"}, 512'(bus.CursorIdx), 512'(m_cur));
    chk({tag, ".turn"}, 512'(bus.Turn), 512'(m_turn));
    chk({tag, ".captured"}, 512'(bus.Captured), 512'(m_capt));
    chk({tag, ".movedone"}, 512'(md_cnt), 512'(m_moves));
  endtask

  function automatic logic [511:0] byte_at(input int i);
    return 512'(bus.Layout[i*8 +: 8]);
  endfunction

  logic [511:0] reset_exp;

  initial begin
    do_reset();
    reset_exp = model_layout();
    chk("rst.b0", byte_at(0), 512'h05);
    chk("rst.b4", byte_at(4), 512'h01);
    chk("rst.b60", byte_at(60), 512'h09);
    chk("rst.b52", byte_at(52), 512'h1E);
    chk("rst.b20", byte_at(20), 512'h00);
    compare_all("rst");

    KeyUp = 1'b0;
    repeat (2) @(negedge clock);
    KeyUp = 1'b1;
    repeat (15) @(negedge clock);
    chk("bounce.cursor", 512'(bus.CursorIdx), 512'd52);
    press(0);
    chk("up.cursor", 512'(bus.CursorIdx), 512'd44);
    chk("up.b52", byte_at(52), 512'h0E);
    chk("up.b44", byte_at(44), 512'h10);
    compare_all("up");

    do_reset();
    repeat (4) press(2);
    press(2);
    chk("wrap_left", 512'(bus.CursorIdx), 512'd55);
    do_reset();
    repeat (6) press(0);
    press(0);
    chk("wrap_up", 512'(bus.CursorIdx), 512'd60);
    compare_all("wrap");

    do_reset();
    toggle_lock();
    chk("sel.b52", byte_at(52), 512'h2E);
    press(0);
    press(0);
    toggle_lock();
    chk("mv.done", 512'(md_cnt), 512'd1);
    chk("mv.b36", byte_at(36), 512'h1E);
    chk("mv.b52", byte_at(52), 512'h00);
    chk("mv.capt", 512'(bus.Captured), 512'h0);
    chk("mv.turn", 512'(bus.Turn), 512'd0);
    toggle_lock();
    chk("wrong_colour.b36", byte_at(36), 512'h1E);
    repeat (3) press(0);
    toggle_lock();
    chk("dark_sel.b12", byte_at(12), 512'h26);
    toggle_lock();
    chk("deselect.b12", byte_at(12), 512'h16);
    compare_all("deselect");

    toggle_lock();
    @(negedge clock);
    #2 resetApp = 1'b1;
    #1 chk("async_reset", bus.Layout, reset_exp);
    repeat (2) @(negedge clock);
    resetApp = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all("post_reset");

    for (int n = 0; n < 220; n++) begin
      if ($urandom_range(0, 3) == 0) toggle_lock();
      else press(int'($urandom_range(0, 3)));
      compare_all($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chess_layout_writer.md
Name: chess_layout_writer

Overview:
- Writer side of the 512-bit chess layout bus that the chess renderer reads.
- Debounces the four direction keys and the lock switch, moves a cursor over the 8x8 board, and runs a select/confirm state machine.
- Applies piece moves with turn alternation and publishes the registered layout every cycle.
- No move-legality checking beyond colour rules; the renderer consumes Layout unchanged.

Parameters:
- SQUARE_WIDTH, 8: bits per square in Layout.
- CHESS_SQUARES, 64: board squares; square index = row*8 + col, row 0 at the top of the screen.
- DEBOUNCE_CYCLES, 500000: stable cycles required before an input change is accepted (10 ms at 50 MHz).
- DEB_W, 19: debounce counter width, must satisfy 2^DEB_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock.
- resetApp  input  1  asynchronous, active-high reset.
- KeyLeft  input  1  active-low pushbutton, asynchronous to clock.
- KeyUp  input  1  active-low pushbutton.
- KeyDown  input  1  active-low pushbutton.
- KeyRight  input  1  active-low pushbutton.
- LockSwitch  input  1  slide switch; any debounced toggle is one confirm event.
- Layout  output  512  per square byte: [2:0] piece, [3] colour, [5:4] select type, [7:6] always 0.
- CursorIdx  output  6  current cursor square.
- Turn  output  1  side to move: 1 light, 0 dark.
- MoveDone  output  1  one-cycle pulse when a move is committed.
- Captured  output  4  {colour, piece} of the destination occupant at the last move; 0 if the square was empty.

Behaviour:
- Reset is asynchronous, active-high on resetApp; clock is clock. All state returns to reset values immediately; a pending selection is discarded.
- Piece codes: 0 empty, 1 king, 2 queen, 3 bishop, 4 knight, 5 rook, 6 pawn.
- Colour codes: 0 dark, 1 light.
- Select codes: 0 none, 1 PRESELECT (cursor), 2 SELECT (held source), 3 POSTSELECT (last destination).
- Reset layout:
  - Rows 0/7: R N B Q K B N R. Row 0 is dark, row 7 is light.
  - Rows 1/6: pawns. Row 1 is dark, row 6 is light.
  - Rows 2-5: empty, all select fields 0 except the cursor square.
  - CursorIdx = 52, and square 52 carries PRESELECT.
  - Turn = 1, MoveDone = 0, Captured = 0, FSM in IDLE.
- Input path:
  - Each of the 5 inputs passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A key event is the debounced high-to-low transition (one cycle).
  - A lock event is any debounced transition.
- Cursor movement:
  - Cursor moves one square per key event, the cycle after the event.
  - Left at col 0 goes to col 7 of the same row; Right at col 7 goes to col 0.
  - Up at row 0 goes to row 7; Down at row 7 goes to row 0.
  - Simultaneous key events: priority Up > Down > Left > Right; only one move is applied.
- Select field maintenance:
  - The old cursor square's field reverts to its underlying marker (SELECT, POSTSELECT, or none).
  - The new cursor square gets PRESELECT, except the held source square, which keeps SELECT.
- FSM IDLE:
  - A lock event on a square whose piece is nonzero and whose colour equals Turn latches src = CursorIdx, sets the src field to SELECT, and goes to HELD.
  - Any other lock event is ignored.
- FSM HELD:
  - Lock event with cursor == src: clear SELECT (square shows PRESELECT) and return to IDLE.
  - Lock event on a square holding a piece of colour Turn: ignored, stay in HELD.
  - Lock event otherwise: go to COMMIT.
- FSM COMMIT (exactly one cycle):
  - dest[3:0] = src[3:0]; src byte = 0.
  - The previous POSTSELECT marker is cleared; dest field = POSTSELECT, with PRESELECT shown while the cursor is on dest.
  - Captured = old dest[3:0]; MoveDone = 1 for this cycle; Turn toggles.
  - Return to IDLE.
- Key events during COMMIT are held one cycle and applied in IDLE; none are lost.
- Lock and key events in the same cycle: the cursor move is applied first, and the lock event is evaluated on the updated cursor the next cycle.
- Layout is a registered output; no combinational path from any input to Layout.

Decomposition:
- Shared package chess_pkg holds:
  - piece, colour and select code constants;
  - SQUARE_WIDTH and CHESS_SQUARES;
  - the 512-bit reset-layout constant;
  - FSM state encoding (IDLE, HELD, COMMIT).
- One natural sub-module: key_debouncer (synchroniser + counter + edge outputs), instantiated 5 times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
- Release reset -> Layout byte 0 = 0x05, byte 4 = 0x01, byte 60 = 0x09, byte 52 = 0x1E, byte 20 = 0x00; CursorIdx = 52; Turn = 1.
- Press KeyUp for 2 cycles then release (bounce) -> no cursor move. Hold it 10 cycles -> CursorIdx = 44 exactly once; byte 52 = 0x0E, byte 44 = 0x10.
- From cursor 48: Left -> 55. From cursor 4: Up -> 60.
- At 52, lock toggle -> byte 52 field = SELECT (0x2E). Up twice, then lock -> MoveDone pulses once; byte 36 = 0x1E (cursor on it), byte 52 = 0x00; Captured = 0; Turn = 0.
- Turn = 0, cursor on a light piece, lock -> ignored, state stays IDLE. Select the dark pawn at 12, lock on 12 again -> deselect, IDLE.
- Mid-HELD, assert resetApp -> Layout returns to the reset constant asynchronously, before the next clock edge.
